// File: rtl/servo_pkg.sv
// Default servo timing constants and the pulse-width clamp shared by the bank and its channels.
// Combinational only: no state, no latency, no flow control.
package servo_pkg;

  localparam int unsigned DEF_PRESCALE    = 250;
  localparam int unsigned DEF_FRAME_TICKS = 4000;
  localparam int unsigned DEF_MIN_W       = 200;
  localparam int unsigned DEF_MAX_W       = 400;
  localparam int unsigned DEF_STEP        = 8;

  // Zero passes through untouched because it means "channel disabled", not "shortest pulse".
  function automatic int unsigned clamp_width(input int unsigned data,
                                              input int unsigned min_w,
                                              input int unsigned max_w);
    if (data == 0)          return 0;
    else if (data < min_w)  return min_w;
    else if (data > max_w)  return max_w;
    else                    return data;
  endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo output: clamped target, slewed current width, registered pulse and at-target flag.
// Target lands one cycle after the write; width changes only on frame_start; writes never stall.
module servo_channel
  import servo_pkg::*;
#(
  parameter int unsigned W     = 12,
  parameter int unsigned MIN_W = DEF_MIN_W,
  parameter int unsigned MAX_W = DEF_MAX_W,
  parameter int unsigned STEP  = DEF_STEP
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_wr_en,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_frame_start,
  input  logic [W-1:0] i_tick_cnt,
  output logic         o_out,
  output logic         o_at_target
);

  logic [W-1:0] r_target;
  logic [W-1:0] r_cur;
  logic         r_out;
  logic         r_at_target;

  logic [W-1:0] w_wr_clamped;
  logic [W-1:0] w_tgt_nxt;
  logic [W-1:0] w_cur_nxt;
  logic [W:0]   w_sum;

  assign w_wr_clamped = W'(clamp_width(32'(i_wr_data), MIN_W, MAX_W));
  assign w_tgt_nxt    = i_wr_en ? w_wr_clamped : r_target;
  assign w_sum        = {1'b0, r_cur} + (W+1)'(STEP);

  // Slew uses r_target, so a write landing on the frame_start cycle waits for the next frame.
  always_comb begin
    w_cur_nxt = r_cur;
    if (i_frame_start) begin
      if (r_target == '0) begin
        w_cur_nxt = '0;
      end else if ((r_cur == '0) || (STEP == 0)) begin
        w_cur_nxt = r_target;
      end else if (r_target > r_cur) begin
        w_cur_nxt = (w_sum >= {1'b0, r_target}) ? r_target : w_sum[W-1:0];
      end else if (r_target < r_cur) begin
        w_cur_nxt = ((r_cur - r_target) > W'(STEP)) ? (r_cur - W'(STEP)) : r_target;
      end
    end
  end

  // Comparing against the width about to be loaded keeps the first cycle of a frame consistent
  // with the rest of it, so every frame carries one whole pulse of a single width.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_target    <= '0;
      r_cur       <= '0;
      r_out       <= 1'b0;
      r_at_target <= 1'b1;
    end else begin
      r_target    <= w_tgt_nxt;
      r_cur       <= w_cur_nxt;
      r_out       <= (w_cur_nxt != '0) && (i_tick_cnt < w_cur_nxt);
      r_at_target <= (w_cur_nxt == w_tgt_nxt);
    end
  end

  assign o_out       = r_out;
  assign o_at_target = r_at_target;

endmodule

// File: rtl/servo_pwm_bank.sv
// Servo PWM bank: shared prescaler/frame counter plus one servo_channel per output.
// Outputs are registered (pulse starts one cycle after the frame boundary); writes are never refused.
module servo_pwm_bank
  import servo_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned PRESCALE    = DEF_PRESCALE,
  parameter int unsigned FRAME_TICKS = DEF_FRAME_TICKS,
  parameter int unsigned W           = 12,
  parameter int unsigned MIN_W       = DEF_MIN_W,
  parameter int unsigned MAX_W       = DEF_MAX_W,
  parameter int unsigned STEP        = DEF_STEP,
  parameter int unsigned CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_wr_en,
  input  logic [CH_W-1:0]     i_wr_ch,
  input  logic [W-1:0]        i_wr_data,
  output logic [CHANNELS-1:0] o_out,
  output logic                o_frame_start,
  output logic [CHANNELS-1:0] o_at_target
);

  localparam int unsigned PW = $clog2(PRESCALE);

  logic [PW-1:0] r_presc;
  logic [W-1:0]  r_tick_cnt;
  logic          r_frame_start;
  logic          w_tick;
  logic          w_wrap;

  assign w_tick = (r_presc == PW'(PRESCALE - 1));
  assign w_wrap = w_tick && (r_tick_cnt == W'(FRAME_TICKS - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc       <= '0;
      r_tick_cnt    <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_presc       <= w_tick ? '0 : r_presc + PW'(1);
      r_frame_start <= w_wrap;
      if (w_wrap) begin
        r_tick_cnt <= '0;
      end else if (w_tick) begin
        r_tick_cnt <= r_tick_cnt + W'(1);
      end
    end
  end

  assign o_frame_start = r_frame_start;

  // Out-of-range channel indices match no instance and are dropped.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic w_wr_sel;
    assign w_wr_sel = i_wr_en && (32'(i_wr_ch) == g);

    servo_channel #(
      .W     (W),
      .MIN_W (MIN_W),
      .MAX_W (MAX_W),
      .STEP  (STEP)
    ) u_ch (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_wr_en       (w_wr_sel),
      .i_wr_data     (i_wr_data),
      .i_frame_start (r_frame_start),
      .i_tick_cnt    (r_tick_cnt),
      .o_out         (o_out[g]),
      .o_at_target   (o_at_target[g])
    );
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank with a small frame (2 clocks/tick, 20 ticks/frame).
module tb_servo_pwm_bank;

  localparam int unsigned CHN       = 4;
  localparam int unsigned PRE       = 2;
  localparam int unsigned FT        = 20;
  localparam int unsigned WW        = 5;
  localparam int unsigned CHW       = 3;
  localparam int          FRAME_CYC = PRE * FT;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           wr_en = 1'b0;
  logic [CHW-1:0] wr_ch = '0;
  logic [WW-1:0]  wr_data = '0;
  logic [CHN-1:0] out;
  logic           frame_start;
  logic [CHN-1:0] at_target;

  int n_checks = 0;
  int n_fail   = 0;
  int m_cnt[CHN];

  always #5 clk = ~clk;

  servo_pwm_bank #(
    .CHANNELS    (CHN),
    .PRESCALE    (PRE),
    .FRAME_TICKS (FT),
    .W           (WW),
    .MIN_W       (4),
    .MAX_W       (16),
    .STEP        (2),
    .CH_W        (CHW)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_wr_en       (wr_en),
    .i_wr_ch       (wr_ch),
    .i_wr_data     (wr_data),
    .o_out         (out),
    .o_frame_start (frame_start),
    .o_at_target   (at_target)
  );

  task automatic wr(input int ch, input int data);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_ch   = CHW'(ch);
    wr_data = WW'(data);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic count_frame();
    for (int c = 0; c < CHN; c++) m_cnt[c] = 0;
    repeat (FRAME_CYC) begin
      @(negedge clk);
      for (int c = 0; c < CHN; c++) if (out[c] === 1'b1) m_cnt[c]++;
    end
  endtask

  task automatic wait_frame();
    int n = 0;
    while (frame_start !== 1'b1 && n < 3 * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    if (frame_start !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL frame_timeout: no frame_start within %0d cycles", n);
    end
  endtask

  task automatic measure_frame();
    wait_frame();
    count_frame();
  endtask

  task automatic test_reset();
    int n = 0;
    int viol = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (out !== 4'b0000) begin n_fail++; $display("FAIL reset_out: got %b want 0000", out); end
    n_checks++; if (at_target !== 4'b1111) begin n_fail++; $display("FAIL reset_at_target: got %b want 1111", at_target); end
    n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
    rst = 1'b0;
    while (frame_start !== 1'b1 && n < 100) begin
      @(negedge clk); n++;
      if (out !== 4'b0000) viol++;
    end
    n_checks++; if (n !== 40) begin n_fail++; $display("FAIL first_frame_len: got %0d want 40", n); end
    n = 0;
    do begin
      @(negedge clk); n++;
      if (out !== 4'b0000) viol++;
    end while (frame_start !== 1'b1 && n < 100);
    n_checks++; if (n !== 40) begin n_fail++; $display("FAIL frame_period: got %0d want 40", n); end
    n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL idle_out: got %0d active cycles want 0", viol); end
    n_checks++; if (at_target !== 4'b1111) begin n_fail++; $display("FAIL idle_at_target: got %b want 1111", at_target); end
  endtask

  task automatic test_first_enable();
    wr(0, 10);
    n_checks++; if (at_target[0] !== 1'b0) begin n_fail++; $display("FAIL enable_pending: got %b want 0", at_target[0]); end
    measure_frame();
    n_checks++; if (m_cnt[0] !== 20) begin n_fail++; $display("FAIL enable_width: got %0d want 20", m_cnt[0]); end
    n_checks++; if (m_cnt[1] !== 0) begin n_fail++; $display("FAIL enable_other_ch: got %0d want 0", m_cnt[1]); end
    n_checks++; if (at_target[0] !== 1'b1) begin n_fail++; $display("FAIL enable_at_target: got %b want 1", at_target[0]); end
  endtask

  task automatic test_slew();
    int exp_w[4]  = '{12, 14, 16, 16};
    int exp_at[4] = '{0, 0, 1, 1};
    wr(0, 16);
    n_checks++; if (at_target[0] !== 1'b0) begin n_fail++; $display("FAIL slew_pending: got %b want 0", at_target[0]); end
    for (int f = 0; f < 4; f++) begin
      measure_frame();
      n_checks++;
      if (m_cnt[0] !== exp_w[f] * PRE) begin
        n_fail++; $display("FAIL slew_width[%0d]: got %0d want %0d", f, m_cnt[0], exp_w[f] * PRE);
      end
      n_checks++;
      if (at_target[0] !== exp_at[f][0]) begin
        n_fail++; $display("FAIL slew_at_target[%0d]: got %b want %0d", f, at_target[0], exp_at[f]);
      end
    end
  endtask

  task automatic test_clamp();
    wr(1, 1);
    measure_frame();
    n_checks++; if (m_cnt[1] !== 8) begin n_fail++; $display("FAIL clamp_low: got %0d want 8", m_cnt[1]); end
    n_checks++; if (m_cnt[0] !== 32) begin n_fail++; $display("FAIL clamp_ch0_hold: got %0d want 32", m_cnt[0]); end
    wr(1, 31);
    for (int w = 6; w <= 16; w += 2) begin
      measure_frame();
      n_checks++;
      if (m_cnt[1] !== w * PRE) begin n_fail++; $display("FAIL clamp_high_ramp: got %0d want %0d", m_cnt[1], w * PRE); end
    end
    n_checks++; if (at_target !== 4'b1111) begin n_fail++; $display("FAIL clamp_high_settled: got %b want 1111", at_target); end
    wr(5, 10);
    n_checks++; if (at_target !== 4'b1111) begin n_fail++; $display("FAIL bad_ch_at_target: got %b want 1111", at_target); end
    measure_frame();
    n_checks++; if (m_cnt[0] !== 32 || m_cnt[1] !== 32 || m_cnt[2] !== 0 || m_cnt[3] !== 0) begin
      n_fail++; $display("FAIL bad_ch_widths: got %0d %0d %0d %0d want 32 32 0 0", m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]);
    end
    wr(1, 0);
    n_checks++; if (at_target[1] !== 1'b0) begin n_fail++; $display("FAIL disable_pending: got %b want 0", at_target[1]); end
    measure_frame();
    n_checks++; if (m_cnt[1] !== 0) begin n_fail++; $display("FAIL disable_width: got %0d want 0", m_cnt[1]); end
    n_checks++; if (at_target !== 4'b1111) begin n_fail++; $display("FAIL disable_at_target: got %b want 1111", at_target); end
  endtask

  task automatic test_collision();
    wr(2, 8);
    measure_frame();
    n_checks++; if (m_cnt[2] !== 16) begin n_fail++; $display("FAIL coll_setup: got %0d want 16", m_cnt[2]); end
    n_checks++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL coll_align: got %b want 1", frame_start); end
    wr_en = 1'b1; wr_ch = CHW'(2); wr_data = WW'(12);
    @(posedge clk); #1;
    wr_en = 1'b0;
    count_frame();
    n_checks++; if (m_cnt[2] !== 16) begin n_fail++; $display("FAIL coll_same_frame: got %0d want 16", m_cnt[2]); end
    n_checks++; if (at_target[2] !== 1'b0) begin n_fail++; $display("FAIL coll_at_target: got %b want 0", at_target[2]); end
    measure_frame();
    n_checks++; if (m_cnt[2] !== 20) begin n_fail++; $display("FAIL coll_next_frame: got %0d want 20", m_cnt[2]); end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    wait_frame();
    repeat (3) @(negedge clk);
    n_checks++; if (out[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got %b want 1", out[0]); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out !== 4'b0000) begin n_fail++; $display("FAIL midrst_out: got %b want 0000", out); end
    n_checks++; if (at_target !== 4'b1111) begin n_fail++; $display("FAIL midrst_at_target: got %b want 1111", at_target); end
    n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL midrst_frame_start: got %b want 0", frame_start); end
    @(negedge clk);
    rst = 1'b0;
    while (frame_start !== 1'b1 && n < 100) begin
      @(negedge clk); n++;
    end
    n_checks++; if (n !== 40) begin n_fail++; $display("FAIL midrst_restart: got %0d want 40", n); end
    count_frame();
    n_checks++; if (m_cnt[0] + m_cnt[1] + m_cnt[2] + m_cnt[3] !== 0) begin
      n_fail++; $display("FAIL midrst_stays_off: got %0d %0d %0d %0d want 0 0 0 0", m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]);
    end
  endtask

  initial begin
    test_reset();
    test_first_enable();
    test_slew();
    test_clamp();
    test_collision();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
